packet_gen: RTL and testbench

AXI4-stream packet source that produces the 16-bit framed packets consumed by the team's message-type packet filter. Software or bench logic pushes packet commands (message type and payload length) into a small command queue. The block serializes each command into a header word followed by deterministic payload words, with tlast marking the end of each packet. It is the upstream transmitter in filter test systems and loopback builds.

---
 rtl/packet_pkg.sv | 49 ++++
 rtl/fifo.sv | 47 ++++
 rtl/packet_gen.sv | 180 ++++++++++++++++++
 tb/tb_packet_gen.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/packet_pkg.sv
// packet_pkg: shared types and constants for packet_gen and downstream benches.
// Optional feature macro: PACKET_GEN_CHECKSUM_EN (adds the CHECKSUM state).
package packet_pkg;

   localparam int unsigned MSG_TYPE_WIDTH = 4;
   localparam int unsigned LEN_WIDTH      = 8;

   // Header word layout: {type[3:0], 4'h0, len[7:0]}
   localparam int unsigned HDR_TYPE_MSB = 15;
   localparam int unsigned HDR_TYPE_LSB = 12;
   localparam int unsigned HDR_RSVD_MSB = 11;
   localparam int unsigned HDR_RSVD_LSB = 8;
   localparam int unsigned HDR_LEN_MSB  = 7;
   localparam int unsigned HDR_LEN_LSB  = 0;

   // Message types passed by the downstream packet filter
   localparam int unsigned NUM_PASS_TYPES = 4;
   localparam logic [MSG_TYPE_WIDTH-1:0] PASS_TYPES [NUM_PASS_TYPES] =
      '{4'h0, 4'hA, 4'h5, 4'h3};

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_HEADER   = 2'd1,
`ifdef PACKET_GEN_CHECKSUM_EN
      ST_PAYLOAD  = 2'd2,
      ST_CHECKSUM = 2'd3
`else
      ST_PAYLOAD  = 2'd2
`endif
   } state_t;

   function automatic logic [15:0] make_header(input logic [MSG_TYPE_WIDTH-1:0] msg_type,
                                               input logic [LEN_WIDTH-1:0]      len);
      logic [15:0] hdr;
      hdr = '0;
      hdr[HDR_TYPE_MSB:HDR_TYPE_LSB] = msg_type;
      hdr[HDR_LEN_MSB:HDR_LEN_LSB]   = len;
      return hdr;
   endfunction

   function automatic logic is_pass_type(input logic [MSG_TYPE_WIDTH-1:0] msg_type);
      logic hit;
      hit = 1'b0;
      for (int unsigned i = 0; i < NUM_PASS_TYPES; i++)
         if (PASS_TYPES[i] == msg_type) hit = 1'b1;
      return hit;
   endfunction

endpackage

// File: rtl/fifo.sv
// fifo: synchronous show-ahead FIFO; rd_data is valid whenever !empty.
// DEPTH must be a power of two.
module fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_wr;
   logic             do_rd;

   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rd_data = mem[rd_ptr[AW-1:0]];

   // Pointer update; reset flushes the queue
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage write
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/packet_gen.sv
// packet_gen: AXI4-stream source serializing queued {type,len} commands into
// header + payload packets. Optional macro PACKET_GEN_CHECKSUM_EN appends an
// XOR checksum word to every packet.
module packet_gen
   import packet_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned CMD_DEPTH  = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [MSG_TYPE_WIDTH-1:0] cmd_type,
   input  logic [LEN_WIDTH-1:0]      cmd_len,
   output logic                      out_tvalid,
   input  logic                      out_tready,
   output logic [DATA_WIDTH-1:0]     out_tdata,
   output logic                      out_tlast,
   output logic                      busy,
   output logic [15:0]               pkt_count
);

   if (DATA_WIDTH != 16) begin : g_bad_width
      $fatal(1, "packet_gen: DATA_WIDTH must be 16");
   end
   if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0) begin : g_bad_depth
      $fatal(1, "packet_gen: CMD_DEPTH must be a power of two >= 2");
   end

`ifdef PACKET_GEN_CHECKSUM_EN
   localparam logic CSUM_EN = 1'b1;
`else
   localparam logic CSUM_EN = 1'b0;
`endif

   localparam int unsigned CMD_W = MSG_TYPE_WIDTH + LEN_WIDTH;

   logic [CMD_W-1:0]          q_rd_data;
   logic                      q_full;
   logic                      q_empty;
   logic                      q_push;
   logic                      q_pop;
   logic [MSG_TYPE_WIDTH-1:0] q_type;
   logic [LEN_WIDTH-1:0]      q_len;

   state_t                    state;
   logic [LEN_WIDTH-1:0]      len_r;
   logic [7:0]                idx;
   logic [7:0]                seq;
   logic                      fire;
   logic                      load_hdr;
   logic                      load_pay;
   logic                      pkt_end;
   logic [7:0]                pay_idx_nx;
   logic [15:0]               pay_word;
   logic [15:0]               hdr_word;
`ifdef PACKET_GEN_CHECKSUM_EN
   logic                      load_csum;
   logic [15:0]               csum;
`endif

   assign q_push    = cmd_valid && cmd_ready;
   assign cmd_ready = !q_full;
   assign q_type    = q_rd_data[CMD_W-1:LEN_WIDTH];
   assign q_len     = q_rd_data[LEN_WIDTH-1:0];
   assign busy      = (state != ST_IDLE) || !q_empty;
   assign fire      = out_tvalid && out_tready;

   assign pay_idx_nx = (state == ST_HEADER) ? 8'd0 : idx + 8'd1;
   assign pay_word   = {seq, pay_idx_nx};
   assign hdr_word   = make_header(q_type, q_len);

   fifo #(
      .WIDTH (CMD_W),
      .DEPTH (CMD_DEPTH)
   ) u_cmd_q (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (q_push),
      .wr_data ({cmd_type, cmd_len}),
      .rd_en   (q_pop),
      .rd_data (q_rd_data),
      .full    (q_full),
      .empty   (q_empty)
   );

   // Decide what, if anything, is loaded into the output register this cycle.
   // A packet end with a pending command reloads the header directly, so
   // back-to-back packets have no bubble.
   always_comb begin
      load_hdr = 1'b0;
      load_pay = 1'b0;
      pkt_end  = 1'b0;
`ifdef PACKET_GEN_CHECKSUM_EN
      load_csum = 1'b0;
`endif
      case (state)
         ST_IDLE: load_hdr = !q_empty;
         ST_HEADER: begin
            if (fire) begin
               if (len_r != '0) load_pay = 1'b1;
`ifdef PACKET_GEN_CHECKSUM_EN
               else load_csum = 1'b1;
`else
               else pkt_end = 1'b1;
`endif
            end
         end
         ST_PAYLOAD: begin
            if (fire) begin
               if (idx != len_r - 8'd1) load_pay = 1'b1;
`ifdef PACKET_GEN_CHECKSUM_EN
               else load_csum = 1'b1;
`else
               else pkt_end = 1'b1;
`endif
            end
         end
`ifdef PACKET_GEN_CHECKSUM_EN
         ST_CHECKSUM: pkt_end = fire;
`endif
         default: ;
      endcase
      if (pkt_end && !q_empty) load_hdr = 1'b1;
      q_pop = load_hdr;
   end

   // Output register, FSM state and packet counters
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         len_r      <= '0;
         idx        <= '0;
         seq        <= '0;
         pkt_count  <= '0;
         out_tvalid <= 1'b0;
         out_tlast  <= 1'b0;
         out_tdata  <= '0;
`ifdef PACKET_GEN_CHECKSUM_EN
         csum       <= '0;
`endif
      end else begin
         if (pkt_end) begin
            pkt_count <= pkt_count + 16'd1;
            seq       <= seq + 8'd1;
         end
         if (load_hdr) begin
            state      <= ST_HEADER;
            len_r      <= q_len;
            idx        <= '0;
            out_tvalid <= 1'b1;
            out_tdata  <= hdr_word;
            out_tlast  <= (q_len == '0) && !CSUM_EN;
`ifdef PACKET_GEN_CHECKSUM_EN
            csum       <= hdr_word;
`endif
         end else if (load_pay) begin
            state     <= ST_PAYLOAD;
            idx       <= pay_idx_nx;
            out_tdata <= pay_word;
            out_tlast <= (pay_idx_nx == len_r - 8'd1) && !CSUM_EN;
`ifdef PACKET_GEN_CHECKSUM_EN
            csum      <= csum ^ pay_word;
`endif
`ifdef PACKET_GEN_CHECKSUM_EN
         end else if (load_csum) begin
            state     <= ST_CHECKSUM;
            out_tdata <= csum;
            out_tlast <= 1'b1;
`endif
         end else if (pkt_end) begin
            state      <= ST_IDLE;
            out_tvalid <= 1'b0;
            out_tlast  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_packet_gen.sv
// tb_packet_gen: randomized self-checking bench for packet_gen with a
// packet-level reference model. Honours PACKET_GEN_CHECKSUM_EN.
module tb_packet_gen;
   import packet_pkg::*;

   localparam int unsigned DEPTH = 16;
`ifdef PACKET_GEN_CHECKSUM_EN
   localparam bit CSUM = 1'b1;
   localparam int unsigned T4_N = 6;
   logic [15:0] t4_exp [T4_N] = '{16'h5001, 16'h0000, 16'h5001, 16'h5001, 16'h0100, 16'h5101};
`else
   localparam bit CSUM = 1'b0;
   localparam int unsigned T4_N = 4;
   logic [15:0] t4_exp [T4_N] = '{16'h5001, 16'h0000, 16'h5001, 16'h0100};
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [3:0]  cmd_type = '0;
   logic [7:0]  cmd_len = '0;
   logic        out_tvalid;
   logic        out_tready = 1'b0;
   logic [15:0] out_tdata;
   logic        out_tlast;
   logic        busy;
   logic [15:0] pkt_count;

   packet_gen #(.DATA_WIDTH(16), .CMD_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_type   (cmd_type),
      .cmd_len    (cmd_len),
      .out_tvalid (out_tvalid),
      .out_tready (out_tready),
      .out_tdata  (out_tdata),
      .out_tlast  (out_tlast),
      .busy       (busy),
      .pkt_count  (pkt_count)
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   int unsigned cyc      = 0;
   int unsigned ready_mode = 0;   // 0: low, 1: high, 2: random

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
      end
   endtask

   // Reference model: expected word stream built at command acceptance
   logic [15:0] exp_q[$];
   bit          exp_last_q[$];
   logic [7:0]  m_seq = '0;
   int unsigned m_done = 0;
   logic [15:0] log_q[$];
   int unsigned log_t[$];
   bit          prev_stall = 1'b0;
   logic [15:0] prev_data;
   logic        prev_last;

   function automatic void model_push(input logic [3:0] t, input logic [7:0] l);
      logic [15:0] w;
      logic [15:0] x;
      w = {t, 4'h0, l};
      x = w;
      exp_q.push_back(w);
      exp_last_q.push_back((l == 0) && !CSUM);
      for (int i = 0; i < int'(l); i++) begin
         w = {m_seq, 8'(i)};
         x = x ^ w;
         exp_q.push_back(w);
         exp_last_q.push_back((i == int'(l) - 1) && !CSUM);
      end
      if (CSUM) begin
         exp_q.push_back(x);
         exp_last_q.push_back(1'b1);
      end
      m_seq = m_seq + 8'd1;
   endfunction

   // Monitor: sampled on the falling edge, away from the active edge
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         exp_last_q.delete();
         m_seq = '0;
         m_done = 0;
         prev_stall = 1'b0;
      end else begin
         check("pkt_count", pkt_count, 32'(m_done[15:0]));
         if (prev_stall) begin
            check("hold_tvalid", out_tvalid, 1);
            check("hold_tdata", out_tdata, prev_data);
            check("hold_tlast", out_tlast, prev_last);
         end
         if (out_tvalid && out_tready) begin
            check("word_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               check("tdata", out_tdata, exp_q[0]);
               check("tlast", out_tlast, exp_last_q[0]);
               if (exp_last_q[0]) m_done++;
               void'(exp_q.pop_front());
               void'(exp_last_q.pop_front());
            end
            log_q.push_back(out_tdata);
            log_t.push_back(cyc);
         end
         prev_stall = out_tvalid && !out_tready;
         prev_data  = out_tdata;
         prev_last  = out_tlast;
         if (cmd_valid && cmd_ready) model_push(cmd_type, cmd_len);
      end
   end

   // Sink ready driver
   initial begin
      forever begin
         @(posedge clk);
         #2;
         case (ready_mode)
            0: out_tready = 1'b0;
            1: out_tready = 1'b1;
            default: out_tready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   task automatic do_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      cmd_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Caller is at posedge+1; returns at posedge+1 after the accepting edge
   task automatic push_cmd(input logic [3:0] t, input logic [7:0] l,
                           input int unsigned max_wait, output bit accepted);
      accepted  = 1'b0;
      cmd_valid = 1'b1;
      cmd_type  = t;
      cmd_len   = l;
      for (int unsigned k = 0; k < max_wait && !accepted; k++) begin
         @(negedge clk);
         if (cmd_ready) accepted = 1'b1;
         @(posedge clk);
         #1;
      end
      cmd_valid = 1'b0;
   endtask

   task automatic drain(input int unsigned max_cyc, input string tag);
      bit done;
      done = 1'b0;
      for (int unsigned k = 0; k < max_cyc && !done; k++) begin
         @(posedge clk);
         #1;
         done = (exp_q.size() == 0) && !busy && !out_tvalid;
      end
      check({tag, "_drained"}, done, 1);
   endtask

   initial begin
      #20ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc;
      int unsigned n_acc;
      ready_mode = 0;

      // Reset values
      do_reset();
      @(negedge clk);
      check("rst_tvalid", out_tvalid, 0);
      check("rst_tlast", out_tlast, 0);
      check("rst_tdata", out_tdata, 0);
      check("rst_busy", busy, 0);
      check("rst_pkt_count", pkt_count, 0);
      check("rst_cmd_ready", cmd_ready, 1);
      @(posedge clk);
      #1;

      // Type 0xA len 2 with header latency of two cycles
      ready_mode = 1;
      log_q.delete();
      log_t.delete();
      push_cmd(4'hA, 8'd2, 4, acc);
      check("t1_accept", acc, 1);
      @(negedge clk);
      check("t1_lat_t1_tvalid", out_tvalid, 0);
      @(negedge clk);
      check("t1_lat_t2_tvalid", out_tvalid, 1);
      check("t1_lat_t2_tdata", out_tdata, 16'hA002);
      @(posedge clk);
      #1;
      drain(50, "t1");
      check("t1_size", log_q.size(), CSUM ? 4 : 3);
      if (log_q.size() >= 3) begin
         check("t1_w0", log_q[0], 16'hA002);
         check("t1_w1", log_q[1], 16'h0000);
         check("t1_w2", log_q[2], CSUM ? 16'h0001 : 16'h0001);
      end
      if (CSUM && log_q.size() >= 4) check("t1_csum", log_q[3], 16'hA003);
      @(negedge clk);
      check("t1_pkt_count", pkt_count, 1);
      check("t1_busy", busy, 0);
      @(posedge clk);
      #1;

      // Type 0x3 len 0
      log_q.delete();
      push_cmd(4'h3, 8'd0, 4, acc);
      check("t2_accept", acc, 1);
      drain(50, "t2");
      check("t2_size", log_q.size(), CSUM ? 2 : 1);
      if (log_q.size() >= 1) check("t2_w0", log_q[0], 16'h3000);
      if (CSUM && log_q.size() >= 2) check("t2_csum", log_q[1], 16'h3000);

      // Two queued 0x5 len 1 packets from a fresh seq
      do_reset();
      log_q.delete();
      log_t.delete();
      push_cmd(4'h5, 8'd1, 4, acc);
      check("t4_accept0", acc, 1);
      push_cmd(4'h5, 8'd1, 4, acc);
      check("t4_accept1", acc, 1);
      drain(50, "t4");
      check("t4_size", log_q.size(), T4_N);
      if (log_q.size() == T4_N) begin
         for (int i = 0; i < int'(T4_N); i++) begin
            check("t4_word", log_q[i], t4_exp[i]);
            if (i > 0) check("t4_no_bubble", log_t[i] - log_t[i-1], 1);
         end
      end

      // Randomized commands under random backpressure
      ready_mode = 2;
      for (int n = 0; n < 30; n++) begin
         logic [7:0] l;
         l = ($urandom_range(0, 9) == 0) ? 8'd255 : 8'($urandom_range(0, 12));
         push_cmd(4'($urandom_range(0, 15)), l, 2000, acc);
         check("rnd_accept", acc, 1);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end
      drain(20000, "rnd");

      // Fill the queue with the sink stalled, then reset mid-packet
      do_reset();
      ready_mode = 0;
      n_acc = 0;
      for (int n = 0; n < 20; n++) begin
         push_cmd(4'($urandom_range(0, 15)), 8'd5, 3, acc);
         if (acc) n_acc++;
      end
      check("fill_accepts", n_acc, DEPTH + 1);
      @(negedge clk);
      check("fill_cmd_ready", cmd_ready, 0);
      check("fill_busy", busy, 1);
      @(posedge clk);
      #1;
      ready_mode = 1;
      repeat (3) @(posedge clk);
      #1;
      ready_mode = 0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_tvalid", out_tvalid, 0);
      check("mid_rst_pkt_count", pkt_count, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_cmd_ready", cmd_ready, 1);
      @(posedge clk);
      #1;

      // Recovery after reset
      ready_mode = 2;
      for (int n = 0; n < 6; n++) begin
         push_cmd(4'($urandom_range(0, 15)), 8'($urandom_range(0, 6)), 500, acc);
         check("rec_accept", acc, 1);
      end
      drain(2000, "rec");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
